// File: rtl/div_seq_unit_pkg.sv
// div_seq_unit_pkg: shared definitions for the iterative divider.
//   - div_state_e : FSM state encodings (DivFree, DivByZero, DivOn, DivEnd)
//   - DivStart/DivStop, DivResultReady/DivResultNotReady handshake levels
//   - ZeroWord and datapath widths
//   - abs_word(): magnitude of an operand, honouring signedness
package div_seq_unit_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned CountWidth = 6;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [DataWidth-1:0] ZeroWord = '0;

    // Two's-complement magnitude; unsigned operands pass through untouched.
    function automatic logic [DataWidth-1:0] abs_word(input logic is_signed,
                                                      input logic [DataWidth-1:0] value);
        if (is_signed && value[DataWidth-1]) begin
            abs_word = ZeroWord - value;
        end else begin
            abs_word = value;
        end
    endfunction

endpackage

// File: rtl/div_clz32.sv
// div_clz32: 32-bit leading-zero counter.
//   value : in  32  word to inspect
//   count : out 6   number of leading zeros (32 when value is zero)
module div_clz32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle restoring radix-2 divider for DIV/DIVU in EX.
//   clk          : in  1   pipeline clock
//   rst          : in  1   asynchronous active-high reset
//   signed_div_i : in  1   1 = DIV, 0 = DIVU (sampled at accept)
//   opdata1_i    : in  32  dividend (sampled at accept)
//   opdata2_i    : in  32  divisor (sampled at accept)
//   start_i      : in  1   request, held by EX until ready_o
//   annul_i      : in  1   abort the operation in flight
//   result_o     : out 64  {remainder, quotient}, registered
//   ready_o      : out 1   result valid, registered
// Optional build macro DIV_EARLY_TERM_EN: skip the leading-zero iterations of
// the dividend magnitude (a zero dividend completes like a divide by zero).
module div_seq_unit
    import div_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    div_state_e            state;
    logic [CountWidth-1:0] counter;
    // {rem[32:0], dvd/quotient[31:0]}
    logic [64:0]           work;
    logic [31:0]           divisor;
    logic                  dvd_neg;
    logic                  dvs_neg;
    logic                  signed_op;

    logic [31:0]           dvd_abs;
    logic [31:0]           dvs_abs;
    logic [64:0]           shifted;
    logic [32:0]           trial;
    logic [64:0]           work_next;
    logic [31:0]           q_fix;
    logic [31:0]           r_fix;

    logic [64:0]           start_work;
    logic [CountWidth-1:0] start_count;
    logic                  dvd_zero;

    assign dvd_abs = abs_word(signed_div_i, opdata1_i);
    assign dvs_abs = abs_word(signed_div_i, opdata2_i);

`ifdef DIV_EARLY_TERM_EN
    logic [5:0] lz;

    div_clz32 u_clz (
        .value (dvd_abs),
        .count (lz)
    );

    // The skipped iterations would only shift zeros into a zero remainder.
    assign start_work  = {33'b0, dvd_abs << lz};
    assign start_count = lz;
    assign dvd_zero    = (dvd_abs == ZeroWord);
`else
    assign start_work  = {33'b0, dvd_abs};
    assign start_count = '0;
    assign dvd_zero    = 1'b0;
`endif

    // One restoring step: shift, trial-subtract, keep the difference if it did not borrow.
    always_comb begin
        shifted = {work[63:0], 1'b0};
        trial   = shifted[64:32] - {1'b0, divisor};
        if (!trial[32]) begin
            work_next = {trial, shifted[31:1], 1'b1};
        end else begin
            work_next = shifted;
        end
    end

    // Sign fixups applied to the result of the final iteration.
    always_comb begin
        q_fix = work_next[31:0];
        r_fix = work_next[63:32];
        if (signed_op && (dvd_neg ^ dvs_neg)) begin
            q_fix = ZeroWord - work_next[31:0];
        end
        if (signed_op && dvd_neg) begin
            r_fix = ZeroWord - work_next[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DivFree;
            counter   <= '0;
            work      <= '0;
            divisor   <= ZeroWord;
            dvd_neg   <= 1'b0;
            dvs_neg   <= 1'b0;
            signed_op <= 1'b0;
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    ready_o <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == ZeroWord || dvd_zero) begin
                            state <= DivByZero;
                        end else begin
                            work      <= start_work;
                            divisor   <= dvs_abs;
                            dvd_neg   <= signed_div_i & opdata1_i[31];
                            dvs_neg   <= signed_div_i & opdata2_i[31];
                            signed_op <= signed_div_i;
                            counter   <= start_count;
                            state     <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    result_o <= '0;
                    ready_o  <= DivResultReady;
                    state    <= DivEnd;
                end
                DivOn: begin
                    // Abort takes priority over a completing iteration.
                    if (annul_i || start_i == DivStop) begin
                        ready_o <= DivResultNotReady;
                        state   <= DivFree;
                    end else begin
                        work    <= work_next;
                        counter <= counter + 6'd1;
                        if (counter == 6'd31) begin
                            result_o <= {r_fix, q_fix};
                            ready_o  <= DivResultReady;
                            state    <= DivEnd;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                        state    <= DivFree;
                    end
                end
                default: begin
                    state <= DivFree;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_unit.sv
module tb_div_seq_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_checks = 0;
    int n_errors = 0;

    div_seq_unit #(
        .WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Edges from accept (counted as 1) to the edge that raises ready_o.
    function automatic int exp_latency(input logic s, input logic [31:0] a,
                                       input logic [31:0] b);
        longint m;
        if (b == 32'd0) return 2;
        m = s ? longint'($signed(a)) : longint'({32'd0, a});
        if (m < 0) m = -m;
`ifdef DIV_EARLY_TERM_EN
        if (m == 0) return 2;
        return 1 + $clog2(m + 1);
`else
        return 33;
`endif
    endfunction

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        int edges;
        logic [63:0] exp;
        exp = model(s, a, b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        edges        = 0;
        while (1) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready_o === 1'b1) break;
            if (edges >= 40) begin
                check({tag, "_timeout"}, 64'(edges), 64'(exp_latency(s, a, b)));
                start_i = 1'b0;
                return;
            end
        end
        check({tag, "_latency"}, 64'(edges), 64'(exp_latency(s, a, b)));
        check({tag, "_result"}, result_o, exp);
        // Operand changes after accept must not disturb the held result.
        @(negedge clk);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_hold_result"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    // Starts 100/7, aborts after iteration 10 by annul (use_annul) or by dropping start.
    task automatic run_abort(input logic use_annul, input string tag);
        logic rose;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        if (use_annul) annul_i = 1'b1;
        else start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_abort_ready"}, 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        rose = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) rose = 1'b1;
        end
        check({tag, "_never_ready"}, 64'(rose), 64'd0);
    endtask

    initial begin
        logic s;
        logic [31:0] a, b;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, "u100_7");
        check("u100_7_const", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, "s_m7_2");
        run_div(1'b1, 32'h7, 32'hFFFFFFFE, "s_7_m2");
        run_div(1'b0, 32'd5, 32'd0, "u5_0");
        run_div(1'b1, 32'd5, 32'd0, "s5_0");
        run_div(1'b0, 32'd9, 32'hFFFFFFFF, "u9_max");
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "s_ovf");
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, "umax_1");
        run_div(1'b0, 32'd0, 32'd3, "u0_3");

        run_abort(1'b1, "annul");
        run_div(1'b0, 32'd9, 32'd3, "after_annul");
        run_abort(1'b0, "stopdrop");
        run_div(1'b0, 32'd9, 32'd3, "after_stop");

        // Asynchronous reset mid-ON, between clock edges.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        check("rst_on_ready", 64'(ready_o), 64'd0);
        check("rst_on_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while a result is held in END.
        @(negedge clk);
        opdata1_i = 32'd50;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        start_i   = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        repeat (34) @(posedge clk);
        #1;
        check("end_before_rst", result_o, model(1'b0, 32'd77, 32'd5));
        #2;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, "after_rst");

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = 32'($urandom_range(1, 300)); end
                2: begin a = 32'($urandom_range(0, 5000)); b = 32'($urandom_range(1, 40)); end
                default: begin a = $urandom; b = -32'($urandom_range(1, 20)); end
            endcase
            run_div(s, a, b, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
